// File: rtl/mirfak_div_pkg.sv
// Shared definitions for the Mirfak iterative divider.
// Provides the command encodings, FSM state type, and the two's-complement
// magnitude helper used for operand and result sign handling.
package mirfak_div_pkg;

    localparam logic [1:0] DIV_CMD_DIV  = 2'b00;
    localparam logic [1:0] DIV_CMD_DIVU = 2'b01;
    localparam logic [1:0] DIV_CMD_REM  = 2'b10;
    localparam logic [1:0] DIV_CMD_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

    // Conditional two's-complement negation on a 64-bit carrier.
    // Callers zero-extend their operand and truncate the result back to
    // XLEN. The low XLEN bits are correct modulo 2^XLEN, which is all
    // that the callers use.
    function automatic logic [63:0] twos_mag(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/mirfak_div_step.sv
// One combinational restoring-division step.
//   rem_i : 2*XLEN partial remainder. The upper half is the running
//           remainder and the lower half holds the unconsumed dividend
//           bits, MSB first.
//   div_i : divisor magnitude.
//   rem_o : partial remainder after shift-and-conditional-subtract.
//   q_o   : quotient bit produced by this step.
module mirfak_div_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] rem_i,
    input  logic [XLEN-1:0]   div_i,
    output logic [2*XLEN-1:0] rem_o,
    output logic              q_o
);
    logic [XLEN:0] diff;

    // The running remainder is always below the divisor, so the shifted
    // window fits in XLEN+1 bits. Bit XLEN of the difference acts as
    // the borrow flag.
    always_comb begin
        diff = rem_i[2*XLEN-1:XLEN-1] - {1'b0, div_i};
        q_o  = ~diff[XLEN];
        if (q_o) begin
            rem_o = {diff[XLEN-1:0], rem_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = {rem_i[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mirfak_div_unit.sv
// Iterative integer divider implementing RISC-V DIV, DIVU, REM and REMU.
// It resolves STEP quotient bits per cycle. Divide-by-zero and signed
// overflow bypass the iteration and complete with fixed results.
//   clk_i, rst_i      : clock and synchronous active-high reset
//   div_op1, div_op2  : dividend and divisor, sampled only on accept
//   div_cmd           : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_enable        : request, held until div_ack or div_kill
//   div_kill          : flush; aborts any operation and suppresses its ack
//   div_result        : result, held until the next completion
//   div_ack           : single-cycle completion pulse
//   div_busy          : high while in CALC or FIN
module mirfak_div_unit
    import mirfak_div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    input  logic [1:0]      div_cmd,
    input  logic            div_enable,
    input  logic            div_kill,
    output logic [XLEN-1:0] div_result,
    output logic            div_ack,
    output logic            div_busy
);
    localparam int CNT_W = (XLEN / STEP > 1) ? $clog2(XLEN / STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN / STEP - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ack_q, ack_d;
    logic [2*XLEN-1:0] pr_q, pr_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_rem_q, is_rem_d;
    logic              sgn_q_q, sgn_q_d;
    logic              sgn_r_q, sgn_r_d;

    logic              signed_cmd;
    logic [2*XLEN-1:0] chain [STEP+1];
    logic [STEP-1:0]   qbits;

    assign chain[0] = pr_q;

    // Quotient bits come out MSB first along the chain.
    for (genvar g = 0; g < STEP; g++) begin : g_step
        mirfak_div_step #(.XLEN(XLEN)) u_step (
            .rem_i (chain[g]),
            .div_i (dvsr_q),
            .rem_o (chain[g+1]),
            .q_o   (qbits[STEP-1-g])
        );
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        ack_d      = 1'b0;
        pr_d       = pr_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        is_rem_d   = is_rem_q;
        sgn_q_d    = sgn_q_q;
        sgn_r_d    = sgn_r_q;
        signed_cmd = ~div_cmd[0];

        case (state_q)
            ST_IDLE: begin
                // While ack_q is high, a still-asserted enable belongs to
                // the operation that just completed.
                if (div_enable && !ack_q) begin
                    is_rem_d = div_cmd[1];
                    cnt_d    = CNT_INIT;
                    quot_d   = '0;
                    dvsr_d   = XLEN'(twos_mag(64'(div_op2), signed_cmd & div_op2[XLEN-1]));
                    pr_d     = {{XLEN{1'b0}},
                                XLEN'(twos_mag(64'(div_op1), signed_cmd & div_op1[XLEN-1]))};
                    sgn_q_d  = (div_cmd == DIV_CMD_DIV) & (div_op1[XLEN-1] ^ div_op2[XLEN-1]);
                    sgn_r_d  = (div_cmd == DIV_CMD_REM) & div_op1[XLEN-1];
                    state_d  = ST_CALC;
                    if (div_op2 == '0) begin
                        quot_d  = '1;
                        pr_d    = {div_op1, {XLEN{1'b0}}};
                        sgn_q_d = 1'b0;
                        sgn_r_d = 1'b0;
                        state_d = ST_FIN;
                    end else if (signed_cmd && div_op1 == MOST_NEG && div_op2 == '1) begin
                        quot_d  = div_op1;
                        pr_d    = '0;
                        sgn_q_d = 1'b0;
                        sgn_r_d = 1'b0;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_CALC: begin
                pr_d   = chain[STEP];
                quot_d = {quot_q[XLEN-STEP-1:0], qbits};
                if (cnt_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIN: begin
                result_d = is_rem_q ? XLEN'(twos_mag(64'(pr_q[2*XLEN-1:XLEN]), sgn_r_q))
                                    : XLEN'(twos_mag(64'(quot_q), sgn_q_q));
                ack_d    = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (div_kill) begin
            state_d  = ST_IDLE;
            ack_d    = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no reset. They are always loaded on accept.
    always_ff @(posedge clk_i) begin
        pr_q     <= pr_d;
        quot_q   <= quot_d;
        dvsr_q   <= dvsr_d;
        cnt_q    <= cnt_d;
        is_rem_q <= is_rem_d;
        sgn_q_q  <= sgn_q_d;
        sgn_r_q  <= sgn_r_d;
    end

    assign div_result = result_q;
    assign div_ack    = ack_q;
    assign div_busy   = (state_q == ST_CALC) || (state_q == ST_FIN);

endmodule
